memory_stage: RTL and testbench
===============================

# memory_stage

Memory-access stage of the five-stage pipeline and the producer side of the MEM/WB latch. It takes the EX/MEM latch outputs and issues data-memory requests on the datapath–cache interface. It stalls the pipeline until the cache answers, then presents the selected result and the carried control to the MEM/WB latch inputs together with that latch's enable and flush. It also holds the LL/SC link register and a sticky halt flag.

## Interface
Parameters:
- LLSC_EN, 1, 1 = LL/SC support; 0 = LL behaves as LW and SC as SW with result 1.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- valid_EX  in  1  EX/MEM slot holds a real instruction
- aluout_EX, rtdata_EX, instr_EX, imemaddr_EX  in  32 each (word_t)  address/ALU result, store data, instruction, PC
- opcode_EX  in  opcode_t;  funct_EX  in  funct_t;  imm16_EX  in  16
- MemRead_EX, MemWrite_EX, MemtoReg_EX, RegWr_EX  in  1 each;  RegDst_EX  in  2
- flush_in  in  1  hazard-unit request to bubble the MEM/WB slot
- dhit  in  1  cache handshake;  dmemload  in  32  load data
- link_inv, link_inv_addr  in  1 / 32  coherence invalidate of a word address
- dmemREN, dmemWEN  out  1;  dmemaddr, dmemstore  out  32
- mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- Output_Port_MEM, instr_MEM, imemaddr_MEM  out  32
- MemtoReg_MEM, RegWr_MEM  out  1;  RegDst_MEM  out  2;  opcode_MEM  out  opcode_t;  funct_MEM  out  funct_t;  imm16_MEM  out  16
- enable, flush  out  1  MEM/WB latch controls
- halt  out  1  sticky, set when a HALT retires through this stage

## Operation
- FSM states: IDLE, WAIT, DONE. Reset: IDLE; link_valid=0; link_addr=0; halt=0; load register=0; pending_flush=0.
- IDLE, no memory op (valid_EX=0 or MemRead/MemWrite both 0): pass-through. Output_Port_MEM=aluout_EX. enable=1, mem_stall=0.
- IDLE, memory op: assert dmemREN or dmemWEN with dmemaddr=aluout_EX and dmemstore=rtdata_EX. Set mem_stall=1 and enable=0. If dhit is high in the same cycle, go to DONE; otherwise go to WAIT.
- WAIT: hold the request and address stable, keep mem_stall=1 and enable=0, and go to DONE on dhit. The load data is registered on the dhit cycle.
- DONE: deassert the request. mem_stall=0, enable=1. Output_Port_MEM = load register for loads, or the SC result for SC. Then go to IDLE.
- SC (opcode SC) with link_valid=1 and link_addr==aluout_EX: issue the write as a normal store. The result is 1.
- SC that fails: no memory request. Completes in one cycle with Output_Port_MEM=0 and RegWr forced to 1.
- LL completion in DONE: link_valid=1 and link_addr=aluout_EX.
- Any completed store or SC to link_addr clears link_valid.
- link_inv with link_inv_addr==link_addr clears link_valid. Invalidate in the same cycle as the SC check: the SC fails.
- flush_in in IDLE: flush=1 this cycle.
- flush_in in WAIT: the access is still completed, and pending_flush is set. In DONE, flush=1 and the LL link is not updated; pending_flush is then cleared.
- halt is set when opcode HALT is valid and enable=1. It is cleared only by reset.
- Outputs during reset: request, mem_stall, enable, flush and halt are 0. Data outputs are 0.

## Timing
- Non-memory op: 0 added cycles; the latch captures on the next edge.
- Memory op: mem_stall is high from the issue cycle through the dhit cycle. The latch captures in the DONE cycle. Latency is dhit cycle + 1.
- Latency examples: dhit in the issue cycle gives 1 stall cycle; dhit after N WAIT cycles gives N+1 stall cycles.
- dmemaddr, dmemstore and the request must not change while the FSM is in WAIT.
- nRST low mid-access: return to IDLE immediately and drop the request. The cache is reset by the same nRST.

## Structure
- word_t, opcode_t and funct_t, plus the LL, SC and HALT opcode constants, come from cpu_types_pkg.
- The FSM state enum mem_state_t is added to cpu_types_pkg.
- One sub-module: link_reg (link_valid/link_addr, set/clear/invalidate priority, match output).

## Test plan
- ADD passthrough, aluout_EX=0x0000_0010 -> Output_Port_MEM=0x10; enable=1 the same cycle; mem_stall never high.
- LW at 0x40 with dhit after 3 cycles and dmemload=0xDEAD_BEEF -> mem_stall high for 4 cycles; DONE shows Output_Port_MEM=0xDEADBEEF and MemtoReg_MEM=1.
- LL at 0x80, then SC at 0x80 with rtdata=5 -> dmemWEN issued; Output_Port_MEM=1.
- LL at 0x80, then link_inv at 0x80, then SC -> no dmemWEN; Output_Port_MEM=0; RegWr_MEM=1.
- flush_in pulsed during the WAIT of an LL -> the access completes; flush=1 in DONE; a following SC fails.
- HALT valid -> halt=1 on the next edge and stays set; nRST pulsed during WAIT -> dmemREN=0 and halt=0 at once.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word, opcode/funct encodings and the MEM-stage FSM state.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [5:0] {
        RTYPE = 6'b000000,
        ADDIU = 6'b001001,
        LW    = 6'b100011,
        SW    = 6'b101011,
        LL    = 6'b110000,
        SC    = 6'b111000,
        HALT  = 6'b111111
    } opcode_t;

    typedef enum logic [5:0] {
        SLL  = 6'b000000,
        ADD  = 6'b100000,
        ADDU = 6'b100001,
        SUB  = 6'b100010,
        SUBU = 6'b100011
    } funct_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } mem_state_t;

endpackage

// File: rtl/memory_stage_link_reg.sv
// LL/SC link register: remembers the last LL address until a store, SC or coherence
// invalidate to that word clears it; `match` answers the SC check for checkAddr.
module link_reg
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  setLink,
    input  word_t setAddr,
    input  logic  clrStore,
    input  word_t storeAddr,
    input  logic  inv,
    input  word_t invAddr,
    input  word_t checkAddr,
    output logic  match
);

    logic  linkValid;
    word_t linkAddr;
    logic  invHit;
    logic  storeHit;

    always_comb begin
        invHit   = inv && (invAddr == linkAddr);
        storeHit = clrStore && (storeAddr == linkAddr);
        // A same-cycle invalidate wins over the SC check
        match    = linkValid && (linkAddr == checkAddr) && !invHit;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            linkValid <= 1'b0;
            linkAddr  <= '0;
        end else if (setLink) begin
            linkValid <= !(inv && (invAddr == setAddr));
            linkAddr  <= setAddr;
        end else if (invHit || storeHit) begin
            linkValid <= 1'b0;
        end
    end

endmodule

// File: rtl/memory_stage.sv
// MEM stage: issues data-cache requests from the EX/MEM latch, stalls until dhit,
// and drives the MEM/WB latch inputs, enable and flush; also owns LL/SC link and halt.
module memory_stage
    import cpu_types_pkg::*;
#(
    parameter bit LLSC_EN = 1'b1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        valid_EX,
    input  word_t       aluout_EX,
    input  word_t       rtdata_EX,
    input  word_t       instr_EX,
    input  word_t       imemaddr_EX,
    input  opcode_t     opcode_EX,
    input  funct_t      funct_EX,
    input  logic [15:0] imm16_EX,
    input  logic        MemRead_EX,
    input  logic        MemWrite_EX,
    input  logic        MemtoReg_EX,
    input  logic        RegWr_EX,
    input  logic [1:0]  RegDst_EX,
    input  logic        flush_in,
    input  logic        dhit,
    input  word_t       dmemload,
    input  logic        link_inv,
    input  word_t       link_inv_addr,
    output logic        dmemREN,
    output logic        dmemWEN,
    output word_t       dmemaddr,
    output word_t       dmemstore,
    output logic        mem_stall,
    output word_t       Output_Port_MEM,
    output word_t       instr_MEM,
    output word_t       imemaddr_MEM,
    output logic        MemtoReg_MEM,
    output logic        RegWr_MEM,
    output logic [1:0]  RegDst_MEM,
    output opcode_t     opcode_MEM,
    output funct_t      funct_MEM,
    output logic [15:0] imm16_MEM,
    output logic        enable,
    output logic        flush,
    output logic        halt
);

    mem_state_t state, nextState;

    word_t reqAddr, reqStore, loadReg;
    logic  reqRen, reqWen, reqSc, reqLl;
    logic  pendingFlush;
    logic  haltReg;

    logic  isScOp, isLlOp, linkMatch, scFail, issue;
    logic  setLink, clrStore, haltSet;

    always_comb begin
        isScOp = (opcode_EX == SC);
        isLlOp = LLSC_EN && (opcode_EX == LL);
        scFail = LLSC_EN && valid_EX && isScOp && !linkMatch;
        issue  = (state == IDLE) && valid_EX && (MemRead_EX || MemWrite_EX) && !scFail;
    end

    assign setLink  = (state == DONE) && reqLl && !pendingFlush;
    assign clrStore = (state == DONE) && reqWen;
    assign haltSet  = valid_EX && (opcode_EX == HALT) && enable;
    assign halt     = haltReg;

    link_reg u_linkReg (
        .CLK       (CLK),
        .nRST      (nRST),
        .setLink   (setLink),
        .setAddr   (reqAddr),
        .clrStore  (clrStore),
        .storeAddr (reqAddr),
        .inv       (link_inv),
        .invAddr   (link_inv_addr),
        .checkAddr (aluout_EX),
        .match     (linkMatch)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state        <= IDLE;
            reqAddr      <= '0;
            reqStore     <= '0;
            reqRen       <= 1'b0;
            reqWen       <= 1'b0;
            reqSc        <= 1'b0;
            reqLl        <= 1'b0;
            loadReg      <= '0;
            pendingFlush <= 1'b0;
            haltReg      <= 1'b0;
        end else begin
            state <= nextState;
            // Request is latched at issue so WAIT drives it from registers, not the EX inputs
            if (issue) begin
                reqAddr  <= aluout_EX;
                reqStore <= rtdata_EX;
                reqRen   <= MemRead_EX;
                reqWen   <= MemWrite_EX;
                reqSc    <= isScOp;
                reqLl    <= isLlOp;
            end
            if (dhit && (issue || (state == WAIT)))
                loadReg <= dmemload;
            if (state == DONE)
                pendingFlush <= 1'b0;
            else if (flush_in && (issue || (state == WAIT)))
                pendingFlush <= 1'b1;
            if (haltSet)
                haltReg <= 1'b1;
        end
    end

    always_comb begin
        nextState       = state;
        dmemREN         = 1'b0;
        dmemWEN         = 1'b0;
        dmemaddr        = '0;
        dmemstore       = '0;
        mem_stall       = 1'b0;
        enable          = 1'b0;
        flush           = 1'b0;
        Output_Port_MEM = '0;
        instr_MEM       = '0;
        imemaddr_MEM    = '0;
        MemtoReg_MEM    = 1'b0;
        RegWr_MEM       = 1'b0;
        RegDst_MEM      = '0;
        opcode_MEM      = RTYPE;
        funct_MEM       = SLL;
        imm16_MEM       = '0;
        if (nRST) begin
            Output_Port_MEM = aluout_EX;
            instr_MEM       = instr_EX;
            imemaddr_MEM    = imemaddr_EX;
            MemtoReg_MEM    = MemtoReg_EX;
            RegWr_MEM       = RegWr_EX;
            RegDst_MEM      = RegDst_EX;
            opcode_MEM      = opcode_EX;
            funct_MEM       = funct_EX;
            imm16_MEM       = imm16_EX;
            unique case (state)
                IDLE: begin
                    flush = flush_in;
                    if (issue) begin
                        dmemREN   = MemRead_EX;
                        dmemWEN   = MemWrite_EX;
                        dmemaddr  = aluout_EX;
                        dmemstore = rtdata_EX;
                        mem_stall = 1'b1;
                        nextState = dhit ? DONE : WAIT;
                    end else begin
                        enable = 1'b1;
                        if (scFail) begin
                            Output_Port_MEM = '0;
                            RegWr_MEM       = 1'b1;
                        end
                    end
                end
                WAIT: begin
                    dmemREN   = reqRen;
                    dmemWEN   = reqWen;
                    dmemaddr  = reqAddr;
                    dmemstore = reqStore;
                    mem_stall = 1'b1;
                    if (dhit)
                        nextState = DONE;
                end
                DONE: begin
                    enable    = 1'b1;
                    flush     = pendingFlush || flush_in;
                    nextState = IDLE;
                    if (reqSc)
                        Output_Port_MEM = 32'd1;
                    else if (reqRen)
                        Output_Port_MEM = loadReg;
                end
                default: nextState = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: expectations are queued when an instruction is
// driven and popped when the stage presents it to the MEM/WB latch (enable high).
module tb_memory_stage;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        valid_EX;
    word_t       aluout_EX, rtdata_EX, instr_EX, imemaddr_EX;
    opcode_t     opcode_EX;
    funct_t      funct_EX;
    logic [15:0] imm16_EX;
    logic        MemRead_EX, MemWrite_EX, MemtoReg_EX, RegWr_EX;
    logic [1:0]  RegDst_EX;
    logic        flush_in, dhit, link_inv;
    word_t       dmemload, link_inv_addr;
    logic        dmemREN, dmemWEN, mem_stall;
    word_t       dmemaddr, dmemstore, Output_Port_MEM, instr_MEM, imemaddr_MEM;
    logic        MemtoReg_MEM, RegWr_MEM, enable, flush, halt;
    logic [1:0]  RegDst_MEM;
    opcode_t     opcode_MEM;
    funct_t      funct_MEM;
    logic [15:0] imm16_MEM;

    int unsigned assertCount = 0;
    int unsigned failCount   = 0;

    typedef struct {
        string name;
        word_t out;
        logic  regWr;
        logic  memToReg;
        logic  flush;
        word_t instr;
    } exp_t;

    exp_t expQ[$];

    always #5 CLK = ~CLK;

    memory_stage #(.LLSC_EN(1'b1)) dut (
        .CLK(CLK), .nRST(nRST), .valid_EX(valid_EX),
        .aluout_EX(aluout_EX), .rtdata_EX(rtdata_EX), .instr_EX(instr_EX),
        .imemaddr_EX(imemaddr_EX), .opcode_EX(opcode_EX), .funct_EX(funct_EX),
        .imm16_EX(imm16_EX), .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX),
        .MemtoReg_EX(MemtoReg_EX), .RegWr_EX(RegWr_EX), .RegDst_EX(RegDst_EX),
        .flush_in(flush_in), .dhit(dhit), .dmemload(dmemload),
        .link_inv(link_inv), .link_inv_addr(link_inv_addr),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .mem_stall(mem_stall), .Output_Port_MEM(Output_Port_MEM), .instr_MEM(instr_MEM),
        .imemaddr_MEM(imemaddr_MEM), .MemtoReg_MEM(MemtoReg_MEM), .RegWr_MEM(RegWr_MEM),
        .RegDst_MEM(RegDst_MEM), .opcode_MEM(opcode_MEM), .funct_MEM(funct_MEM),
        .imm16_MEM(imm16_MEM), .enable(enable), .flush(flush), .halt(halt)
    );

    // Scoreboard monitor: one pop per instruction handed to the MEM/WB latch
    always @(negedge CLK) begin
        if (nRST && valid_EX && enable) begin
            assertCount++;
            if (expQ.size() == 0) begin
                failCount++;
                $display("FAIL sb_unexpected: got out=%h with no expectation queued", Output_Port_MEM);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                assertCount++;
                if (Output_Port_MEM !== e.out) begin
                    failCount++;
                    $display("FAIL %s_out: got %h expected %h", e.name, Output_Port_MEM, e.out);
                end
                assertCount++;
                if (RegWr_MEM !== e.regWr) begin
                    failCount++;
                    $display("FAIL %s_regwr: got %b expected %b", e.name, RegWr_MEM, e.regWr);
                end
                assertCount++;
                if (MemtoReg_MEM !== e.memToReg) begin
                    failCount++;
                    $display("FAIL %s_memtoreg: got %b expected %b", e.name, MemtoReg_MEM, e.memToReg);
                end
                assertCount++;
                if (flush !== e.flush) begin
                    failCount++;
                    $display("FAIL %s_flush: got %b expected %b", e.name, flush, e.flush);
                end
                assertCount++;
                if (instr_MEM !== e.instr) begin
                    failCount++;
                    $display("FAIL %s_instr: got %h expected %h", e.name, instr_MEM, e.instr);
                end
            end
        end
    end

    function automatic word_t mkInstr(input opcode_t op, input word_t tag);
        word_t w;
        w = {op, tag[25:0]};
        return w;
    endfunction

    function automatic exp_t mkExp(input string nm, input word_t o, input logic rw,
                                   input logic m2r, input logic fl, input word_t ins);
        exp_t e;
        e.name = nm; e.out = o; e.regWr = rw; e.memToReg = m2r; e.flush = fl; e.instr = ins;
        return e;
    endfunction

    // Drives one instruction and acts as the cache; entered and left at posedge+1.
    task automatic doOp(input opcode_t op, input logic mr, input logic mw, input logic m2r,
                        input logic rw, input word_t alu, input word_t rt,
                        input int unsigned hitDelay, input word_t loadVal,
                        input int unsigned flushAt, output int unsigned stalls,
                        output logic sawWen, output logic unstable,
                        output word_t firstStore, output logic timedOut);
        int unsigned reqCount = 0;
        int unsigned cyc = 0;
        word_t firstAddr = '0;
        logic done = 1'b0;
        stalls = 0; sawWen = 1'b0; unstable = 1'b0; firstStore = '0; timedOut = 1'b1;
        valid_EX = 1'b1; opcode_EX = op; funct_EX = ADD; imm16_EX = alu[15:0];
        MemRead_EX = mr; MemWrite_EX = mw; MemtoReg_EX = m2r; RegWr_EX = rw;
        aluout_EX = alu; rtdata_EX = rt; instr_EX = mkInstr(op, alu); imemaddr_EX = alu + 32'h1000;
        for (int i = 0; i < 60; i++) begin
            #1;
            cyc++;
            flush_in = (flushAt != 0) && (cyc == flushAt);
            if (dmemREN || dmemWEN) begin
                if (reqCount == 0) begin
                    firstAddr = dmemaddr;
                    firstStore = dmemstore;
                end else if (dmemaddr !== firstAddr || dmemstore !== firstStore) begin
                    unstable = 1'b1;
                end
                if (dmemWEN) sawWen = 1'b1;
                dhit = (reqCount == hitDelay);
                dmemload = loadVal;
                reqCount++;
            end else begin
                dhit = 1'b0;
            end
            @(negedge CLK);
            if (mem_stall) stalls++;
            if (enable) done = 1'b1;
            @(posedge CLK);
            #1;
            dhit = 1'b0; flush_in = 1'b0; link_inv = 1'b0;
            if (done) begin
                valid_EX = 1'b0; MemRead_EX = 1'b0; MemWrite_EX = 1'b0;
                timedOut = 1'b0;
                break;
            end
        end
        valid_EX = 1'b0;
    endtask

    task automatic idleCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        valid_EX = 1'b1; opcode_EX = LW; MemRead_EX = 1'b1; aluout_EX = 32'h40;
        instr_EX = mkInstr(LW, 32'h40); RegWr_EX = 1'b1; MemtoReg_EX = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        assertCount++;
        if (dmemREN !== 1'b0 || dmemWEN !== 1'b0) begin
            failCount++; $display("FAIL reset_req: got ren=%b wen=%b expected 0", dmemREN, dmemWEN);
        end
        assertCount++;
        if (mem_stall !== 1'b0 || enable !== 1'b0 || flush !== 1'b0) begin
            failCount++;
            $display("FAIL reset_ctrl: got stall=%b en=%b flush=%b expected 0", mem_stall, enable, flush);
        end
        assertCount++;
        if (halt !== 1'b0) begin
            failCount++; $display("FAIL reset_halt: got %b expected 0", halt);
        end
        assertCount++;
        if (Output_Port_MEM !== 32'h0 || dmemaddr !== 32'h0) begin
            failCount++;
            $display("FAIL reset_data: got out=%h addr=%h expected 0", Output_Port_MEM, dmemaddr);
        end
        valid_EX = 1'b0; MemRead_EX = 1'b0;
        nRST = 1'b1;
        idleCycle();
    endtask

    task automatic test_passthrough();
        int unsigned st; logic w, u, to; word_t fs;
        word_t vals[4];
        vals[0] = 32'h0000_0010; vals[1] = 32'hFFFF_FFFF; vals[2] = 32'h0; vals[3] = $urandom;
        for (int i = 0; i < 4; i++) begin
            expQ.push_back(mkExp("add_pass", vals[i], 1'b1, 1'b0, 1'b0, mkInstr(RTYPE, vals[i])));
            doOp(RTYPE, 1'b0, 1'b0, 1'b0, 1'b1, vals[i], 32'h0, 0, 32'h0, 0, st, w, u, fs, to);
            assertCount++;
            if (to !== 1'b0 || st != 0) begin
                failCount++; $display("FAIL pass_stall: got stalls=%0d timeout=%b expected 0", st, to);
            end
        end
        // flush_in with no memory op bubbles the slot this very cycle
        expQ.push_back(mkExp("idle_flush", 32'h20, 1'b1, 1'b0, 1'b1, mkInstr(RTYPE, 32'h20)));
        doOp(RTYPE, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20, 32'h0, 0, 32'h0, 1, st, w, u, fs, to);
        assertCount++;
        if (to !== 1'b0 || st != 0) begin
            failCount++; $display("FAIL idle_flush_stall: got stalls=%0d expected 0", st);
        end
    endtask

    task automatic test_load();
        int unsigned st; logic w, u, to; word_t fs;
        expQ.push_back(mkExp("lw_wait", 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, mkInstr(LW, 32'h40)));
        doOp(LW, 1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0, 3, 32'hDEAD_BEEF, 0, st, w, u, fs, to);
        assertCount++;
        if (to !== 1'b0 || st != 4) begin
            failCount++; $display("FAIL lw_wait_stall: got %0d timeout=%b expected 4", st, to);
        end
        assertCount++;
        if (u !== 1'b0) begin
            failCount++; $display("FAIL lw_wait_stable: got unstable=%b expected 0", u);
        end
        expQ.push_back(mkExp("lw_hit", 32'h1234_5678, 1'b1, 1'b1, 1'b0, mkInstr(LW, 32'h44)));
        doOp(LW, 1'b1, 1'b0, 1'b1, 1'b1, 32'h44, 32'h0, 0, 32'h1234_5678, 0, st, w, u, fs, to);
        assertCount++;
        if (to !== 1'b0 || st != 1) begin
            failCount++; $display("FAIL lw_hit_stall: got %0d timeout=%b expected 1", st, to);
        end
    endtask

    task automatic test_llsc();
        int unsigned st; logic w, u, to; word_t fs;
        expQ.push_back(mkExp("ll", 32'h77, 1'b1, 1'b1, 1'b0, mkInstr(LL, 32'h80)));
        doOp(LL, 1'b1, 1'b0, 1'b1, 1'b1, 32'h80, 32'h0, 1, 32'h77, 0, st, w, u, fs, to);
        expQ.push_back(mkExp("sc_ok", 32'h1, 1'b1, 1'b0, 1'b0, mkInstr(SC, 32'h80)));
        doOp(SC, 1'b0, 1'b1, 1'b0, 1'b1, 32'h80, 32'h5, 1, 32'h0, 0, st, w, u, fs, to);
        assertCount++;
        if (w !== 1'b1 || fs !== 32'h5 || st != 2) begin
            failCount++;
            $display("FAIL sc_ok_req: got wen=%b store=%h stalls=%0d expected 1/5/2", w, fs, st);
        end
        // The successful SC consumed the link, so a repeat SC must fail
        expQ.push_back(mkExp("sc_again", 32'h0, 1'b1, 1'b0, 1'b0, mkInstr(SC, 32'h80)));
        doOp(SC, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80, 32'h6, 1, 32'h0, 0, st, w, u, fs, to);
        assertCount++;
        if (w !== 1'b0 || st != 0 || to !== 1'b0) begin
            failCount++; $display("FAIL sc_again_req: got wen=%b stalls=%0d expected 0/0", w, st);
        end
    endtask

    task automatic test_link_inv();
        int unsigned st; logic w, u, to; word_t fs;
        expQ.push_back(mkExp("ll_inv", 32'h11, 1'b1, 1'b1, 1'b0, mkInstr(LL, 32'h80)));
        doOp(LL, 1'b1, 1'b0, 1'b1, 1'b1, 32'h80, 32'h0, 0, 32'h11, 0, st, w, u, fs, to);
        link_inv = 1'b1; link_inv_addr = 32'h80;
        idleCycle();
        link_inv = 1'b0;
        expQ.push_back(mkExp("sc_inv", 32'h0, 1'b1, 1'b0, 1'b0, mkInstr(SC, 32'h80)));
        doOp(SC, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80, 32'h5, 0, 32'h0, 0, st, w, u, fs, to);
        assertCount++;
        if (w !== 1'b0 || st != 0) begin
            failCount++; $display("FAIL sc_inv_req: got wen=%b stalls=%0d expected 0/0", w, st);
        end
        // Invalidate of a neighbouring word leaves the link intact
        expQ.push_back(mkExp("ll_other", 32'h22, 1'b1, 1'b1, 1'b0, mkInstr(LL, 32'h80)));
        doOp(LL, 1'b1, 1'b0, 1'b1, 1'b1, 32'h80, 32'h0, 0, 32'h22, 0, st, w, u, fs, to);
        link_inv = 1'b1; link_inv_addr = 32'h84;
        idleCycle();
        link_inv = 1'b0;
        expQ.push_back(mkExp("sc_other", 32'h1, 1'b1, 1'b0, 1'b0, mkInstr(SC, 32'h80)));
        doOp(SC, 1'b0, 1'b1, 1'b0, 1'b1, 32'h80, 32'h9, 0, 32'h0, 0, st, w, u, fs, to);
        assertCount++;
        if (w !== 1'b1 || st != 1) begin
            failCount++; $display("FAIL sc_other_req: got wen=%b stalls=%0d expected 1/1", w, st);
        end
        // Invalidate arriving in the same cycle as the SC check
        expQ.push_back(mkExp("ll_same", 32'h33, 1'b1, 1'b1, 1'b0, mkInstr(LL, 32'h90)));
        doOp(LL, 1'b1, 1'b0, 1'b1, 1'b1, 32'h90, 32'h0, 0, 32'h33, 0, st, w, u, fs, to);
        link_inv = 1'b1; link_inv_addr = 32'h90;
        expQ.push_back(mkExp("sc_same", 32'h0, 1'b1, 1'b0, 1'b0, mkInstr(SC, 32'h90)));
        doOp(SC, 1'b0, 1'b1, 1'b0, 1'b0, 32'h90, 32'h5, 0, 32'h0, 0, st, w, u, fs, to);
        assertCount++;
        if (w !== 1'b0 || st != 0) begin
            failCount++; $display("FAIL sc_same_req: got wen=%b stalls=%0d expected 0/0", w, st);
        end
    endtask

    task automatic test_flush_wait();
        int unsigned st; logic w, u, to; word_t fs;
        expQ.push_back(mkExp("ll_flush", 32'h55, 1'b1, 1'b1, 1'b1, mkInstr(LL, 32'h80)));
        doOp(LL, 1'b1, 1'b0, 1'b1, 1'b1, 32'h80, 32'h0, 3, 32'h55, 2, st, w, u, fs, to);
        assertCount++;
        if (to !== 1'b0 || st != 4) begin
            failCount++; $display("FAIL ll_flush_stall: got %0d timeout=%b expected 4", st, to);
        end
        expQ.push_back(mkExp("sc_after_flush", 32'h0, 1'b1, 1'b0, 1'b0, mkInstr(SC, 32'h80)));
        doOp(SC, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80, 32'h5, 0, 32'h0, 0, st, w, u, fs, to);
        assertCount++;
        if (w !== 1'b0) begin
            failCount++; $display("FAIL sc_after_flush_req: got wen=%b expected 0", w);
        end
    endtask

    task automatic test_halt();
        int unsigned st; logic w, u, to; word_t fs;
        assertCount++;
        if (halt !== 1'b0) begin
            failCount++; $display("FAIL halt_pre: got %b expected 0", halt);
        end
        expQ.push_back(mkExp("halt", 32'hC0, 1'b0, 1'b0, 1'b0, mkInstr(HALT, 32'hC0)));
        doOp(HALT, 1'b0, 1'b0, 1'b0, 1'b0, 32'hC0, 32'h0, 0, 32'h0, 0, st, w, u, fs, to);
        assertCount++;
        if (halt !== 1'b1) begin
            failCount++; $display("FAIL halt_set: got %b expected 1", halt);
        end
        repeat (3) idleCycle();
        assertCount++;
        if (halt !== 1'b1) begin
            failCount++; $display("FAIL halt_sticky: got %b expected 1", halt);
        end
    endtask

    task automatic test_reset_mid();
        int unsigned st; logic w, u, to; word_t fs;
        valid_EX = 1'b1; opcode_EX = LW; MemRead_EX = 1'b1; MemWrite_EX = 1'b0;
        aluout_EX = 32'h100; instr_EX = mkInstr(LW, 32'h100); dhit = 1'b0;
        @(posedge CLK);
        #1;
        assertCount++;
        if (dmemREN !== 1'b1 || mem_stall !== 1'b1) begin
            failCount++; $display("FAIL wait_req: got ren=%b stall=%b expected 1/1", dmemREN, mem_stall);
        end
        #2 nRST = 1'b0;
        #1;
        assertCount++;
        if (dmemREN !== 1'b0 || mem_stall !== 1'b0 || halt !== 1'b0) begin
            failCount++;
            $display("FAIL mid_reset: got ren=%b stall=%b halt=%b expected 0/0/0", dmemREN, mem_stall, halt);
        end
        valid_EX = 1'b0; MemRead_EX = 1'b0;
        @(posedge CLK);
        #1 nRST = 1'b1;
        idleCycle();
        expQ.push_back(mkExp("post_reset", 32'h7, 1'b1, 1'b0, 1'b0, mkInstr(RTYPE, 32'h7)));
        doOp(RTYPE, 1'b0, 1'b0, 1'b0, 1'b1, 32'h7, 32'h0, 0, 32'h0, 0, st, w, u, fs, to);
        assertCount++;
        if (to !== 1'b0 || st != 0) begin
            failCount++; $display("FAIL post_reset_stall: got %0d timeout=%b expected 0", st, to);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        valid_EX = 1'b0; aluout_EX = '0; rtdata_EX = '0; instr_EX = '0; imemaddr_EX = '0;
        opcode_EX = RTYPE; funct_EX = ADD; imm16_EX = '0;
        MemRead_EX = 1'b0; MemWrite_EX = 1'b0; MemtoReg_EX = 1'b0; RegWr_EX = 1'b0;
        RegDst_EX = 2'b01; flush_in = 1'b0; dhit = 1'b0; dmemload = '0;
        link_inv = 1'b0; link_inv_addr = '0;
        test_reset();
        test_passthrough();
        test_load();
        test_llsc();
        test_link_inv();
        test_flush_wait();
        test_halt();
        test_reset_mid();
        assertCount++;
        if (expQ.size() != 0) begin
            failCount++; $display("FAIL sb_drain: got %0d pending expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
